// File: rtl/ahb_ddr3_cmd_bridge.sv
// AHB-Lite slave that queues word transfers and issues DDR3 commands over a
// valid/ready port, tracking open rows per bank so PRE/ACT appear only on misses.
module ahb_ddr3_cmd_bridge #(
  parameter int DATA_W     = 32,
  parameter int BA_BITS    = 3,
  parameter int ROW_BITS   = 14,
  parameter int COL_BITS   = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic                          HSEL,
  input  logic [31:0]                   HADDR,
  input  logic                          HWRITE,
  input  logic [1:0]                    HTRANS,
  input  logic [2:0]                    HSIZE,
  input  logic [2:0]                    HBURST,
  input  logic [DATA_W-1:0]             HWDATA,
  output logic                          HREADY,
  output logic [1:0]                    HRESP,
  output logic [DATA_W-1:0]             HRDATA,
  output logic [4:0]                    cmd,
  output logic [BA_BITS-1:0]            ba,
  output logic [ROW_BITS-1:0]           row,
  output logic [COL_BITS-1:0]           col,
  output logic [DATA_W-1:0]             wdata,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  input  logic                          rd_valid,
  input  logic [DATA_W-1:0]             rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W    = PTR_W + 1;
  localparam int unsigned NBANK    = 2 ** BA_BITS;
  localparam int unsigned BA_LSB   = 2 + COL_BITS;
  localparam int unsigned ROW_LSB  = BA_LSB + BA_BITS;
  localparam int unsigned ADDR_TOP = ROW_LSB + ROW_BITS;
  localparam logic [31:0] ADDR_USED = (ADDR_TOP >= 32) ? 32'hFFFF_FFFC :
                                      (((32'd1 << ADDR_TOP) - 32'd1) & 32'hFFFF_FFFC);

  typedef enum logic [2:0] {
    D_IDLE, D_WRITE, D_READ_PUSH, D_READ_WAIT, D_READ_DONE, D_ERR1, D_ERR2
  } dstate_e;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_ACT, S_RW} istate_e;

  typedef enum logic [4:0] {
    CMD_NOP = 5'd2, CMD_ACT = 5'd6, CMD_RD = 5'd7, CMD_WR = 5'd8, CMD_PRE = 5'd13
  } cmd_e;

  typedef struct packed {
    logic                wr;
    logic [BA_BITS-1:0]  ba;
    logic [ROW_BITS-1:0] row;
    logic [COL_BITS-1:0] col;
    logic [DATA_W-1:0]   wdata;
  } entry_t;

  dstate_e d_state, d_nxt;
  istate_e i_state;

  logic                dp_write;
  logic [BA_BITS-1:0]  dp_ba;
  logic [ROW_BITS-1:0] dp_row;
  logic [COL_BITS-1:0] dp_col;

  entry_t              mem [FIFO_DEPTH];
  entry_t              head, entry_in;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [LVL_W-1:0]    level_nxt;
  logic                full, full_nxt, push, pop, accept, hready_nxt;

  logic [NBANK-1:0]                   bank_open;
  logic [NBANK-1:0][ROW_BITS-1:0]     bank_row;

  logic unused_bits;
  assign unused_bits = ^{HBURST, HTRANS[0], HADDR & ~ADDR_USED};

  assign full   = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign pop    = (i_state == S_RW) && cmd_ready;
  assign accept = HSEL && HTRANS[1] && HREADY;
  assign head   = mem[rd_ptr];

  always_comb begin
    entry_in.wr    = dp_write;
    entry_in.ba    = dp_ba;
    entry_in.row   = dp_row;
    entry_in.col   = dp_col;
    entry_in.wdata = dp_write ? HWDATA : '0;
  end

  // HREADY/HRESP are registered, so their next value is derived from the
  // next data-phase state and the next full flag.
  always_comb begin
    d_nxt = d_state;
    push  = 1'b0;
    unique case (d_state)
      D_WRITE:     push = !full;
      D_READ_PUSH: if (!full) begin
                     push  = 1'b1;
                     d_nxt = D_READ_WAIT;
                   end
      D_READ_WAIT: if (rd_valid) d_nxt = D_READ_DONE;
      D_ERR1:      d_nxt = D_ERR2;
      default:     ;
    endcase
    if (HREADY) begin
      if (accept)
        d_nxt = (HSIZE != 3'b010) ? D_ERR1 : (HWRITE ? D_WRITE : D_READ_PUSH);
      else
        d_nxt = D_IDLE;
    end

    level_nxt = fifo_level;
    if (push && !pop)      level_nxt = fifo_level + LVL_W'(1);
    else if (pop && !push) level_nxt = fifo_level - LVL_W'(1);
    full_nxt = (level_nxt == LVL_W'(FIFO_DEPTH));

    unique case (d_nxt)
      D_WRITE:                          hready_nxt = !full_nxt;
      D_READ_PUSH, D_READ_WAIT, D_ERR1: hready_nxt = 1'b0;
      default:                          hready_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      d_state  <= D_IDLE;
      HREADY   <= 1'b1;
      HRESP    <= 2'b00;
      HRDATA   <= '0;
      dp_write <= 1'b0;
      dp_ba    <= '0;
      dp_row   <= '0;
      dp_col   <= '0;
    end else begin
      d_state <= d_nxt;
      HREADY  <= hready_nxt;
      HRESP   <= (d_nxt == D_ERR1 || d_nxt == D_ERR2) ? 2'b01 : 2'b00;
      if (accept) begin
        dp_write <= HWRITE;
        dp_col   <= HADDR[2 +: COL_BITS];
        dp_ba    <= HADDR[BA_LSB +: BA_BITS];
        dp_row   <= HADDR[ROW_LSB +: ROW_BITS];
      end
      if (d_state == D_READ_WAIT && rd_valid)
        HRDATA <= rd_data;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_level <= level_nxt;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr] <= entry_in;
  end

  // The head entry stays in the FIFO until its RD/WR is accepted, so all
  // command fields can be reloaded from it in every state.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      i_state   <= S_IDLE;
      cmd       <= CMD_NOP;
      cmd_valid <= 1'b0;
      ba        <= '0;
      row       <= '0;
      col       <= '0;
      wdata     <= '0;
      bank_open <= '0;
      bank_row  <= '0;
    end else begin
      unique case (i_state)
        S_IDLE: begin
          if (fifo_level != '0) begin
            cmd_valid <= 1'b1;
            ba        <= head.ba;
            row       <= head.row;
            col       <= head.col;
            wdata     <= head.wdata;
            if (bank_open[head.ba] && bank_row[head.ba] == head.row) begin
              i_state <= S_RW;
              cmd     <= head.wr ? CMD_WR : CMD_RD;
            end else if (bank_open[head.ba]) begin
              i_state <= S_PRE;
              cmd     <= CMD_PRE;
            end else begin
              i_state <= S_ACT;
              cmd     <= CMD_ACT;
            end
          end
        end
        S_PRE: begin
          if (cmd_ready) begin
            bank_open[ba] <= 1'b0;
            i_state       <= S_ACT;
            cmd           <= CMD_ACT;
          end
        end
        S_ACT: begin
          if (cmd_ready) begin
            bank_open[ba] <= 1'b1;
            bank_row[ba]  <= row;
            i_state       <= S_RW;
            cmd           <= head.wr ? CMD_WR : CMD_RD;
          end
        end
        S_RW: begin
          if (cmd_ready) begin
            i_state   <= S_IDLE;
            cmd       <= CMD_NOP;
            cmd_valid <= 1'b0;
          end
        end
        default: i_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_ddr3_cmd_bridge.sv
// Directed bench: stimulus pushes expected DDR3 commands into a scoreboard queue,
// a monitor compares them on each command handshake, a responder returns read data.
module tb_ahb_ddr3_cmd_bridge;
  localparam int DATA_W = 32, BA_BITS = 3, ROW_BITS = 14, COL_BITS = 10, FIFO_DEPTH = 4;
  localparam int TIMEOUT = 300;

  logic                  HCLK = 1'b0;
  logic                  HRESET, HSEL, HWRITE;
  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic [2:0]            HSIZE, HBURST;
  logic [DATA_W-1:0]     HWDATA;
  logic                  HREADY;
  logic [1:0]            HRESP;
  logic [DATA_W-1:0]     HRDATA;
  logic [4:0]            cmd;
  logic [BA_BITS-1:0]    ba;
  logic [ROW_BITS-1:0]   row;
  logic [COL_BITS-1:0]   col;
  logic [DATA_W-1:0]     wdata;
  logic                  cmd_valid, cmd_ready, rd_valid;
  logic [DATA_W-1:0]     rd_data;
  logic [2:0]            fifo_level;

  always #5 HCLK = ~HCLK;

  ahb_ddr3_cmd_bridge #(
    .DATA_W(DATA_W), .BA_BITS(BA_BITS), .ROW_BITS(ROW_BITS),
    .COL_BITS(COL_BITS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .cmd(cmd), .ba(ba), .row(row), .col(col), .wdata(wdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .fifo_level(fifo_level)
  );

  typedef struct {
    logic [31:0] cmd, ba, row, col, wdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  int          errors = 0;
  int          checks = 0;
  int          stalls[8];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endfunction

  function automatic void exp_push(input logic [31:0] c, input logic [31:0] b,
                                   input logic [31:0] r, input logic [31:0] cl,
                                   input logic [31:0] d);
    exp_t e;
    e.cmd = c; e.ba = b; e.row = r; e.col = cl; e.wdata = d;
    exp_q.push_back(e);
  endfunction

  // Command monitor: a handshake seen at the negedge completes on the next posedge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (!HRESET && cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_cmd");
        end else begin
          e = exp_q.pop_front();
          chk("cmd_code", 32'(cmd), e.cmd);
          chk("cmd_ba", 32'(ba), e.ba);
          if (e.cmd == 32'd6) chk("cmd_row", 32'(row), e.row);
          if (e.cmd == 32'd7 || e.cmd == 32'd8) chk("cmd_col", 32'(col), e.col);
          if (e.cmd == 32'd8) chk("cmd_wdata", wdata, e.wdata);
        end
      end
    end
  end

  // Read responder: rd_valid three cycles after the RD handshake.
  initial begin : responder
    logic [31:0] v;
    rd_valid = 1'b0;
    rd_data  = '0;
    forever begin
      @(negedge HCLK);
      if (!HRESET && cmd_valid && cmd_ready && cmd == 5'd7) begin
        if (rd_q.size() == 0) begin
          fail("unexpected_rd");
          v = 32'h0;
        end else begin
          v = rd_q.pop_front();
        end
        @(posedge HCLK);
        repeat (3) @(posedge HCLK);
        #1 rd_valid = 1'b1;
        rd_data = v;
        @(negedge HCLK);
        chk("rd_wait_hready", 32'(HREADY), 32'd0);
        @(posedge HCLK);
        #1 rd_valid = 1'b0;
        @(negedge HCLK);
        chk("rd_done_hready", 32'(HREADY), 32'd1);
        chk("rd_hrdata", HRDATA, v);
        chk("rd_hresp", 32'(HRESP), 32'd0);
      end
    end
  end

  task automatic wait_ready(output int s);
    s = 0;
    forever begin
      @(negedge HCLK);
      if (HREADY) break;
      s++;
      if (s >= TIMEOUT) begin
        fail("hready_timeout");
        break;
      end
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge HCLK);
      if (fifo_level == 3'd0 && !cmd_valid) break;
      n++;
      if (n >= TIMEOUT) begin
        fail("drain_timeout");
        break;
      end
    end
    chk("drain_level", 32'(fifo_level), 32'd0);
    @(posedge HCLK);
    #1;
  endtask

  task automatic wr_burst(input logic [31:0] a0, input int n, input logic [31:0] d0);
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        HSEL = 1'b1; HWRITE = 1'b1; HSIZE = 3'b010;
        HBURST = (n > 1) ? 3'b001 : 3'b000;
        HTRANS = (i == 0) ? 2'b10 : 2'b11;
        HADDR  = a0 + 32'(i * 4);
      end else begin
        HSEL = 1'b0; HTRANS = 2'b00;
      end
      if (i > 0) HWDATA = d0 + 32'(i - 1);
      wait_ready(stalls[i]);
    end
  endtask

  task automatic rd_single(input logic [31:0] a);
    int s;
    HSEL = 1'b1; HWRITE = 1'b0; HSIZE = 3'b010; HBURST = 3'b000;
    HTRANS = 2'b10; HADDR = a;
    wait_ready(s);
    HSEL = 1'b0; HTRANS = 2'b00;
    wait_ready(s);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HTRANS = 2'b00;
    HSIZE = 3'b010; HBURST = 3'b000; HWDATA = '0; cmd_ready = 1'b0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_hready", 32'(HREADY), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'd2);
    chk("rst_level", 32'(fifo_level), 32'd0);
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    cmd_ready = 1'b1;

    // 0x1004 -> word 0x401: col 1, ba 1, row 0; bank closed
    exp_push(32'd6, 32'd1, 32'd0, 32'd0, 32'd0);
    exp_push(32'd8, 32'd1, 32'd0, 32'd1, 32'hDEADBEEF);
    wr_burst(32'h0000_1004, 1, 32'hDEADBEEF);
    wait_idle();

    // same row: WR only
    exp_push(32'd8, 32'd1, 32'd0, 32'd2, 32'hCAFEF00D);
    wr_burst(32'h0000_1008, 1, 32'hCAFEF00D);
    wait_idle();

    // 0x9004 -> word 0x2401: col 1, ba 1, row 1; row miss
    exp_push(32'd13, 32'd1, 32'd0, 32'd0, 32'd0);
    exp_push(32'd6,  32'd1, 32'd1, 32'd0, 32'd0);
    exp_push(32'd8,  32'd1, 32'd0, 32'd1, 32'h11112222);
    wr_burst(32'h0000_9004, 1, 32'h11112222);
    wait_idle();

    // FIFO full: five SEQ writes to ba 1 row 1 (open), cols 4..8
    cmd_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      exp_push(32'd8, 32'd1, 32'd0, 32'(4 + k), 32'hA000_0000 + 32'(k));
    fork
      wr_burst(32'h0000_9010, 5, 32'hA000_0000);
      begin
        repeat (12) @(negedge HCLK);
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_hready", 32'(HREADY), 32'd0);
        @(posedge HCLK);
        #1 cmd_ready = 1'b1;
      end
    join
    chk("burst_stall_beat4", 32'(stalls[4]), 32'd0);
    chk("burst_stall_beat5", 32'(stalls[5] > 0), 32'd1);
    wait_idle();

    // read 0x40 -> word 0x10: col 0x10, ba 0, row 0; bank 0 closed
    exp_push(32'd6, 32'd0, 32'd0, 32'd0, 32'd0);
    exp_push(32'd7, 32'd0, 32'd0, 32'h10, 32'd0);
    rd_q.push_back(32'h12345678);
    rd_single(32'h0000_0040);
    wait_idle();

    // rd_valid with no read outstanding is ignored
    rd_valid = 1'b1;
    rd_data  = 32'hBADBAD00;
    @(posedge HCLK);
    #1 rd_valid = 1'b0;
    @(negedge HCLK);
    chk("spurious_hrdata", HRDATA, 32'h12345678);
    chk("spurious_hready", 32'(HREADY), 32'd1);
    @(posedge HCLK);
    #1;

    // size error: halfword NONSEQ
    HSEL = 1'b1; HWRITE = 1'b1; HSIZE = 3'b001; HTRANS = 2'b10; HADDR = 32'h100;
    @(posedge HCLK);
    #1 HSEL = 1'b0; HTRANS = 2'b00; HSIZE = 3'b010;
    @(negedge HCLK);
    chk("err1_hready", 32'(HREADY), 32'd0);
    chk("err1_hresp", 32'(HRESP), 32'd1);
    @(negedge HCLK);
    chk("err2_hready", 32'(HREADY), 32'd1);
    chk("err2_hresp", 32'(HRESP), 32'd1);
    chk("err_level", 32'(fifo_level), 32'd0);
    @(negedge HCLK);
    chk("err_after_hresp", 32'(HRESP), 32'd0);
    chk("err_cmd_valid", 32'(cmd_valid), 32'd0);
    @(posedge HCLK);
    #1;

    // reset in the middle of a burst, controller stalled
    cmd_ready = 1'b0;
    HSEL = 1'b1; HWRITE = 1'b1; HSIZE = 3'b010; HBURST = 3'b001;
    HTRANS = 2'b10; HADDR = 32'h0000_9020;
    @(posedge HCLK);
    #1 HTRANS = 2'b11; HADDR = 32'h0000_9024; HWDATA = 32'h0BAD_0001;
    @(posedge HCLK);
    #1 HWDATA = 32'h0BAD_0002;
    @(negedge HCLK);
    chk("prereset_level", 32'(fifo_level), 32'd1);
    @(posedge HCLK);
    #1 HRESET = 1'b1;
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
    chk("midrst_hready", 32'(HREADY), 32'd1);
    chk("midrst_hresp", 32'(HRESP), 32'd0);
    chk("midrst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("midrst_cmd", 32'(cmd), 32'd2);
    chk("midrst_level", 32'(fifo_level), 32'd0);
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    cmd_ready = 1'b1;

    // open-row table cleared: ba 1 row 1 needs ACT again
    exp_push(32'd6, 32'd1, 32'd1, 32'd0, 32'd0);
    exp_push(32'd8, 32'd1, 32'd0, 32'd3, 32'h5555AAAA);
    wr_burst(32'h0000_900C, 1, 32'h5555AAAA);
    wait_idle();

    repeat (2) @(posedge HCLK);
    chk("sb_cmd_empty", 32'(exp_q.size()), 32'd0);
    chk("sb_rd_empty", 32'(rd_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
